// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD scan counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    // Out-of-range digits saturate at 9 rather than wrapping.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with clear/load/step; BCD_UPDOWN_EN enables down counting.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       load,
    input  bcd_digit_t ld_val,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       wrap
);

    bcd_digit_t digit_reg;
    bcd_digit_t digit_next;

`ifdef BCD_UPDOWN_EN
    always_comb begin
        digit_next = digit_reg;
        wrap       = 1'b0;
        if (up_dn) begin
            digit_next = (digit_reg == BCD_MAX) ? 4'd0 : digit_reg + 4'd1;
            wrap       = step && (digit_reg == BCD_MAX);
        end else begin
            digit_next = (digit_reg == 4'd0) ? BCD_MAX : digit_reg - 4'd1;
            wrap       = step && (digit_reg == 4'd0);
        end
    end
`else
    // Direction input is tied off; only the up path exists in this build.
    logic unused_up_dn;
    assign unused_up_dn = up_dn;

    always_comb begin
        digit_next = (digit_reg == BCD_MAX) ? 4'd0 : digit_reg + 4'd1;
        wrap       = step && (digit_reg == BCD_MAX);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_reg <= 4'd0;
        end else if (clr) begin
            digit_reg <= 4'd0;
        end else if (load) begin
            digit_reg <= ld_val;
        end else if (step) begin
            digit_reg <= digit_next;
        end
    end

    assign digit = digit_reg;

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with tick prescaler and digit scanner.
// Optional feature macro: BCD_UPDOWN_EN (down counting via up_dn).
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int SCAN_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       up_dn,
    output logic [7:0] count,
    output logic       tick,
    output logic       carry,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic [1:0] dig_sel
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0] p_reg;
    logic [SW-1:0] s_reg;
    logic [1:0]    dig_sel_reg;
    logic          tick_reg;
    logic          carry_reg;
    logic          step_edge;
    logic          ones_wrap;
    logic          tens_wrap;
    bcd_digit_t    ones_digit;
    bcd_digit_t    tens_digit;
    bcd_digit_t    ld_ones;
    bcd_digit_t    ld_tens;

    // clr and load pre-empt a coinciding step, so the digits never see both.
    assign step_edge = en && (p_reg == P_LAST) && !clr && !load;
    assign ld_ones   = bcd_clamp(load_val[3:0]);
    assign ld_tens   = bcd_clamp(load_val[7:4]);

    always_ff @(posedge clk) begin
        if (rst || clr || load) begin
            p_reg <= '0;
        end else if (en) begin
            p_reg <= (p_reg == P_LAST) ? '0 : p_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg  <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            tick_reg  <= step_edge;
            carry_reg <= step_edge && tens_wrap;
        end
    end

    bcd_digit u_ones (
        .clk    (clk),
        .rst    (rst),
        .step   (step_edge),
        .up_dn  (up_dn),
        .load   (load),
        .ld_val (ld_ones),
        .clr    (clr),
        .digit  (ones_digit),
        .wrap   (ones_wrap)
    );

    bcd_digit u_tens (
        .clk    (clk),
        .rst    (rst),
        .step   (ones_wrap),
        .up_dn  (up_dn),
        .load   (load),
        .ld_val (ld_tens),
        .clr    (clr),
        .digit  (tens_digit),
        .wrap   (tens_wrap)
    );

    // Free-running scanner; deliberately ignores en, clr and load.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg       <= '0;
            dig_sel_reg <= DIG_ONES;
        end else if (s_reg == S_LAST) begin
            s_reg       <= '0;
            dig_sel_reg <= (dig_sel_reg == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end else begin
            s_reg <= s_reg + 1'b1;
        end
    end

    always_comb begin
        {A, B, C, D} = (dig_sel_reg == DIG_TENS) ? tens_digit : ones_digit;
    end

    assign count   = {tens_digit, ones_digit};
    assign tick    = tick_reg;
    assign carry   = carry_reg;
    assign dig_sel = dig_sel_reg;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: integer reference model feeds an expectation queue, monitor compares each cycle.
module tb_bcd_scan_counter;

    localparam int PS = 4;
    localparam int SD = 3;

    logic       clk = 1'b0;
    logic       rst, en, clr, load, up_dn;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick, carry, A, B, C, D;
    logic [1:0] dig_sel;

    typedef struct packed {
        logic [7:0] count;
        logic       tick;
        logic       carry;
        logic [1:0] dig_sel;
        logic [3:0] abcd;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   driver_done = 1'b0;

    // Reference model state: plain integers.
    int m_val = 0, m_p = 0, m_s = 0, m_sel = 0, m_tick = 0, m_carry = 0;

    bcd_scan_counter #(.PRESCALE(PS), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up_dn(up_dn), .count(count), .tick(tick),
        .carry(carry), .A(A), .B(B), .C(C), .D(D), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    // Advance the model across one rising edge with the current inputs.
    task automatic model_edge();
        bit go_up;
`ifdef BCD_UPDOWN_EN
        go_up = up_dn;
`else
        go_up = 1'b1;
`endif
        if (rst) begin
            m_val = 0; m_p = 0; m_s = 0; m_sel = 0; m_tick = 0; m_carry = 0;
            return;
        end
        if (m_s == SD - 1) begin
            m_s = 0;
            m_sel = 1 - m_sel;
        end else begin
            m_s++;
        end
        m_tick = 0;
        m_carry = 0;
        if (clr) begin
            m_val = 0; m_p = 0;
        end else if (load) begin
            m_val = clamp9(int'(load_val[7:4])) * 10 + clamp9(int'(load_val[3:0]));
            m_p = 0;
        end else if (en && m_p == PS - 1) begin
            m_p = 0;
            m_tick = 1;
            if (go_up) begin
                if (m_val == 99) begin m_val = 0; m_carry = 1; end
                else m_val++;
            end else begin
                if (m_val == 0) begin m_val = 99; m_carry = 1; end
                else m_val--;
            end
        end else if (en) begin
            m_p++;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        int tens, ones;
        tens = m_val / 10;
        ones = m_val % 10;
        o.count   = {4'(tens), 4'(ones)};
        o.tick    = 1'(m_tick);
        o.carry   = 1'(m_carry);
        o.dig_sel = m_sel ? 2'b10 : 2'b01;
        o.abcd    = m_sel ? 4'(tens) : 4'(ones);
        return o;
    endfunction

    task automatic drive(input bit r, input bit e, input bit c, input bit l,
                         input logic [7:0] lv, input bit ud);
        rst = r; en = e; clr = c; load = l; load_val = lv; up_dn = ud;
        model_edge();
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    // Monitor: one comparison per clock, sampled 1 time unit after the edge.
    initial begin
        obs_t act, expv;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                expv = exp_q.pop_front();
                act = '{count: count, tick: tick, carry: carry, dig_sel: dig_sel, abcd: {A, B, C, D}};
                checks++;
                cyc++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL cycle%0d: got count=%h tick=%b carry=%b dig_sel=%b abcd=%b, want count=%h tick=%b carry=%b dig_sel=%b abcd=%b",
                             cyc, act.count, act.tick, act.carry, act.dig_sel, act.abcd,
                             expv.count, expv.tick, expv.carry, expv.dig_sel, expv.abcd);
                end else begin
                    $display("cycle%0d ok count=%h tick=%b carry=%b dig_sel=%b abcd=%b",
                             cyc, act.count, act.tick, act.carry, act.dig_sel, act.abcd);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset for two edges, then count up from 00 for 40 cycles.
        drive(1, 0, 0, 0, 8'h00, 1);
        drive(1, 1, 0, 0, 8'h00, 1);
        repeat (40) drive(0, 1, 0, 0, 8'h00, 1);
        // 98 up through 99 to 00 with carry.
        drive(0, 1, 0, 1, 8'h98, 1);
        repeat (2 * PS + 1) drive(0, 1, 0, 0, 8'h00, 1);
        // 00 stepped down (or up when direction is disabled).
        drive(0, 1, 0, 1, 8'h00, 0);
        repeat (PS + 1) drive(0, 1, 0, 0, 8'h00, 0);
        // Clamped load, then clr exactly on a step edge.
        drive(0, 1, 0, 1, 8'hAB, 1);
        repeat (PS - 1) drive(0, 1, 0, 0, 8'h00, 1);
        drive(0, 1, 1, 0, 8'h00, 1);
        repeat (PS + 1) drive(0, 1, 0, 0, 8'h00, 1);
        // Load 47 and hold en low to watch the scanner alternate digits.
        drive(0, 0, 0, 1, 8'h47, 1);
        repeat (4 * SD) drive(0, 0, 0, 0, 8'h00, 1);
        // Reset mid-count while load is held.
        drive(0, 1, 0, 0, 8'h00, 1);
        drive(1, 1, 0, 1, 8'h55, 1);
        drive(0, 1, 0, 0, 8'h00, 1);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            n = $urandom_range(0, 99);
            drive(n == 0, $urandom_range(0, 9) != 0, n >= 96, (n >= 90) && (n < 96),
                  8'($urandom), (i / 37) % 2 == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        driver_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
